// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings, memory-wait FSM state codes, default mult/div latencies and a
// register-match helper used by every hazard and forwarding check.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RF_SEL = 2'b00,
        W_SEL  = 2'b01,
        M_SEL  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // A producer matches a consumer only when it writes a real register ($0 never counts).
    function automatic logic reg_hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    // Youngest producer wins: M before W, register file otherwise.
    function automatic fwd_sel_e fwd_sel(input logic we_m, input logic [4:0] dst_m,
                                         input logic we_w, input logic [4:0] dst_w,
                                         input logic [4:0] src);
        if (reg_hit(we_m, dst_m, src)) return M_SEL;
        if (reg_hit(we_w, dst_w, src)) return W_SEL;
        return RF_SEL;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// slave = the controller, master = the pipeline datapath (or a testbench).
interface hazard_ctrl_if;
    logic [4:0] RsD, RtD, RsE, RtE;
    logic [4:0] RegAddrE, RegAddrM, RegAddrW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       MemtoRegE, MemtoRegM;
    logic       BranchD, MdUseD, MdStartE, MdIsDivE;
    logic       MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushE, FlushM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD;
    logic       MdBusy;

    modport slave (
        input  RsD, RtD, RsE, RtE, RegAddrE, RegAddrM, RegAddrW,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        input  BranchD, MdUseD, MdStartE, MdIsDivE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushE, FlushM,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD, MdBusy
    );

    modport master (
        output RsD, RtD, RsE, RtE, RegAddrE, RegAddrM, RegAddrW,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        output BranchD, MdUseD, MdStartE, MdIsDivE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushE, FlushM,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, MdBusy
    );
endinterface

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Loadable down-counter that tracks how long the mult/div unit stays busy.
// busy is high for exactly the loaded number of cycles after the load edge.
module md_busy_timer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] count_reg;

    // Load on an accepted start (a restart while busy simply reloads), else count down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (start) begin
            count_reg <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign busy = (count_reg != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: forwarding selects,
// load-use / branch / mult-div stalls and the data-memory wait FSM.
// Optional macro HAZARD_PERF_EN adds saturating stall/wait/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]  PerfStallCyc,
    output logic [31:0]  PerfMemWaitCyc,
    output logic [31:0]  PerfFlushE
`endif
);

    mem_state_e state_reg, state_next;
    logic       mem_stall, load_use, branch_haz, md_haz, d_haz, md_busy;
    logic [4:0] src_e [2];
    logic [4:0] src_d [2];
    fwd_sel_e   fwd_e [2];
    logic [1:0] fwd_d, lu_hit, br_hit;

    assign src_e[0] = bus.RsE;
    assign src_e[1] = bus.RtE;
    assign src_d[0] = bus.RsD;
    assign src_d[1] = bus.RtD;

    // Per-operand forwarding and per-source hazard matches (index 0 = Rs, 1 = Rt).
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign fwd_e[gi]  = fwd_sel(bus.RegWriteM, bus.RegAddrM, bus.RegWriteW, bus.RegAddrW, src_e[gi]);
        assign fwd_d[gi]  = reg_hit(bus.RegWriteM, bus.RegAddrM, src_d[gi]);
        assign lu_hit[gi] = reg_hit(bus.MemtoRegE, bus.RegAddrE, src_d[gi]);
        assign br_hit[gi] = reg_hit(bus.RegWriteE, bus.RegAddrE, src_d[gi])
                          || reg_hit(bus.MemtoRegM, bus.RegAddrM, src_d[gi]);
    end

    assign mem_stall  = bus.MemReqM && !bus.MemReadyM;
    assign load_use   = |lu_hit;
    assign branch_haz = bus.BranchD && (|br_hit);
    assign md_haz     = bus.MdUseD && md_busy;
    assign d_haz      = load_use || branch_haz || md_haz;

    // A multiply/divide held in E by a memory stall is not accepted until it can advance.
    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (bus.MdStartE && !mem_stall),
        .is_div (bus.MdIsDivE),
        .busy   (md_busy)
    );

    // Memory wait FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Memory wait FSM next state: enter WAIT on an unanswered request, leave on ready.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.MemReqM && !bus.MemReadyM) state_next = WAIT;
            WAIT:    if (bus.MemReadyM)                 state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory stall freezes everything and bubbles W; D-stage hazards only hold F/D and bubble E.
    assign bus.StallF    = mem_stall || d_haz;
    assign bus.StallD    = mem_stall || d_haz;
    assign bus.StallE    = mem_stall;
    assign bus.StallM    = mem_stall;
    assign bus.FlushE    = d_haz && !mem_stall;
    assign bus.FlushM    = mem_stall;
    assign bus.ForwardAE = fwd_e[0];
    assign bus.ForwardBE = fwd_e[1];
    assign bus.ForwardAD = fwd_d[0];
    assign bus.ForwardBD = fwd_d[1];
    assign bus.MdBusy    = md_busy;

`ifdef HAZARD_PERF_EN
    // Saturating event counters for stall, memory-wait and E-flush cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PerfStallCyc   <= '0;
            PerfMemWaitCyc <= '0;
            PerfFlushE     <= '0;
        end else begin
            if (bus.StallF && (PerfStallCyc != '1))        PerfStallCyc   <= PerfStallCyc + 1'b1;
            if ((state_reg == WAIT) && (PerfMemWaitCyc != '1)) PerfMemWaitCyc <= PerfMemWaitCyc + 1'b1;
            if (bus.FlushE && (PerfFlushE != '1))          PerfFlushE     <= PerfFlushE + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of single-cycle vectors plus
// hand-written multi-cycle sequences, each expectation queued on drive and
// popped when the outputs are sampled.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    typedef struct packed {
        logic [4:0] rs_d, rt_d, rs_e, rt_e, ad_e, ad_m, ad_w;
        logic rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, md_use_d, md_start_e, md_div_e, mem_req, mem_rdy;
    } in_t;

    typedef struct packed {
        logic sf, sd, se, sm, fe, fm;
        logic [1:0] fae, fbe;
        logic fad, fbd, busy;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic clk;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    out_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];

    hazard_ctrl_if hif();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    // Restarting mult/div while it is still busy is a protocol violation.
    always @(posedge clk) begin
        if (reset && hif.MdStartE && hif.MdBusy) begin
            miscompares++;
            $display("FAIL md_protocol: got MdStartE=1 while MdBusy=1, required no start while busy");
        end
    end

    task automatic drive(input in_t v);
        hif.RsD = v.rs_d;  hif.RtD = v.rt_d;  hif.RsE = v.rs_e;  hif.RtE = v.rt_e;
        hif.RegAddrE = v.ad_e;  hif.RegAddrM = v.ad_m;  hif.RegAddrW = v.ad_w;
        hif.RegWriteE = v.rw_e; hif.RegWriteM = v.rw_m; hif.RegWriteW = v.rw_w;
        hif.MemtoRegE = v.m2r_e; hif.MemtoRegM = v.m2r_m; hif.BranchD = v.br_d;
        hif.MdUseD = v.md_use_d; hif.MdStartE = v.md_start_e; hif.MdIsDivE = v.md_div_e;
        hif.MemReqM = v.mem_req; hif.MemReadyM = v.mem_rdy;
    endtask

    function automatic out_t sample();
        out_t s;
        s.sf = hif.StallF;  s.sd = hif.StallD;  s.se = hif.StallE;  s.sm = hif.StallM;
        s.fe = hif.FlushE;  s.fm = hif.FlushM;  s.fae = hif.ForwardAE; s.fbe = hif.ForwardBE;
        s.fad = hif.ForwardAD; s.fbd = hif.ForwardBD; s.busy = hif.MdBusy;
        return s;
    endfunction

    task automatic compare_front();
        out_t  got;
        out_t  e;
        string n;
        got = sample();
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s: got %04h required %04h", n, got, e);
        end else begin
            $display("vec %0d %s outputs %04h", vectors, n, got);
        end
    endtask

    // One pipeline cycle: drive at the falling edge, sample shortly after.
    task automatic step(input string name, input in_t v, input out_t e);
        @(negedge clk);
        drive(v);
        exp_q.push_back(e);
        name_q.push_back(name);
        #1;
        compare_front();
    endtask

    task automatic check_state(input string name, input logic want_wait);
        logic got;
        got = (dut.state_reg == WAIT);
        vectors++;
        if (got !== want_wait) begin
            miscompares++;
            $display("FAIL %s: got in_wait=%0b required in_wait=%0b", name, got, want_wait);
        end else begin
            $display("vec %0d %s in_wait=%0b", vectors, name, got);
        end
    endtask

    task automatic add(input string n, input in_t i, input out_t o);
        vec_t r;
        r.name = n; r.i = i; r.o = o;
        tbl.push_back(r);
    endtask

    initial begin
        in_t  v;
        out_t e, ds, ms, z;

        z  = '0;
        ds = '0; ds.sf = 1; ds.sd = 1; ds.fe = 1;
        ms = '0; ms.sf = 1; ms.sd = 1; ms.se = 1; ms.sm = 1; ms.fm = 1;

        // ---- single-cycle vector table ----
        v = '0; add("idle", v, z);
        v = '0; v.rs_e = 8; v.rw_m = 1; v.ad_m = 8; e = z; e.fae = 2'b10; add("fwdAE_M", v, e);
        v = '0; v.rs_e = 8; v.rw_w = 1; v.ad_w = 8; e = z; e.fae = 2'b01; add("fwdAE_W", v, e);
        v = '0; v.rs_e = 8; v.rw_m = 1; v.ad_m = 8; v.rw_w = 1; v.ad_w = 8; e = z; e.fae = 2'b10; add("fwdAE_M_over_W", v, e);
        v = '0; v.rt_e = 9; v.rw_w = 1; v.ad_w = 9; e = z; e.fbe = 2'b01; add("fwdBE_W", v, e);
        v = '0; v.rw_m = 1; v.rw_w = 1; e = z; add("fwd_zero_reg", v, e);
        v = '0; v.rs_e = 8; v.ad_m = 8; v.ad_w = 8; e = z; add("fwd_no_write", v, e);
        v = '0; v.rs_d = 8; v.rt_d = 8; v.rw_m = 1; v.ad_m = 8; e = z; e.fad = 1; e.fbd = 1; add("fwdD_both", v, e);
        v = '0; v.m2r_e = 1; v.rw_e = 1; v.ad_e = 8; v.rs_d = 8; add("loaduse_rs", v, ds);
        v = '0; v.m2r_e = 1; v.rw_e = 1; v.ad_e = 8; v.rt_d = 8; add("loaduse_rt", v, ds);
        v = '0; v.m2r_e = 1; v.rw_e = 1; add("loaduse_zero_reg", v, z);
        v = '0; v.br_d = 1; v.rw_e = 1; v.ad_e = 5; v.rs_d = 5; add("branch_E", v, ds);
        v = '0; v.br_d = 1; v.m2r_m = 1; v.ad_m = 6; v.rt_d = 6; add("branch_M_load", v, ds);
        v = '0; v.br_d = 1; v.rw_e = 1; add("branch_zero_reg", v, z);
        v = '0; v.rw_e = 1; v.ad_e = 5; v.rs_d = 5; add("no_branch", v, z);
        v = '0; v.mem_req = 1; add("mem_stall", v, ms);
        v = '0; v.mem_req = 1; v.m2r_e = 1; v.ad_e = 8; v.rs_d = 8; add("mem_over_loaduse", v, ms);
        v = '0; v.mem_req = 1; v.mem_rdy = 1; add("mem_ready", v, z);

        // ---- reset state ----
        reset = 1'b0;
        drive('0);
        #3;
        exp_q.push_back(z); name_q.push_back("reset_outputs");
        compare_front();
        check_state("reset_state", 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < tbl.size(); k++) step(tbl[k].name, tbl[k].i, tbl[k].o);

        // ---- lw $8 in E, add $8 in D: one bubble, then W forward ----
        v = '0; v.m2r_e = 1; v.rw_e = 1; v.ad_e = 8; v.rs_d = 8; step("lu_seq_stall", v, ds);
        v = '0; v.m2r_m = 1; v.rw_m = 1; v.ad_m = 8; v.rs_d = 8; e = z; e.fad = 1; step("lu_seq_bubble", v, e);
        v = '0; v.rw_w = 1; v.ad_w = 8; v.rs_e = 8; e = z; e.fae = 2'b01; step("lu_seq_fwdW", v, e);

        // ---- mult then div, mfhi waiting in D ----
        for (int d = 0; d < 2; d++) begin
            int n;
            n = (d == 0) ? 5 : 10;
            v = '0; v.md_start_e = 1; v.md_div_e = d[0]; v.md_use_d = 1; step("md_accept", v, z);
            v = '0; v.md_use_d = 1;
            e = ds; e.busy = 1;
            for (int k = 0; k < n; k++) step((d == 0) ? "mult_busy" : "div_busy", v, e);
            step((d == 0) ? "mult_done" : "div_done", v, z);
        end

        // ---- mult held in E by a memory stall is accepted only when it advances ----
        v = '0; v.md_start_e = 1; v.mem_req = 1; step("md_held_by_mem", v, ms);
        v = '0; v.md_start_e = 1; v.mem_req = 1; v.mem_rdy = 1; step("md_accept_after_mem", v, z);
        v = '0; e = z; e.busy = 1;
        for (int k = 0; k < 5; k++) step("md_late_busy", v, e);
        step("md_late_done", v, z);

        // ---- memory wait 3 cycles ----
        v = '0; v.mem_req = 1;
        step("memwait_1", v, ms); check_state("memwait_1_state", 1'b0);
        step("memwait_2", v, ms); check_state("memwait_2_state", 1'b1);
        step("memwait_3", v, ms); check_state("memwait_3_state", 1'b1);
        v.mem_rdy = 1; step("memwait_ready", v, z); check_state("memwait_ready_state", 1'b1);
        v = '0; step("memwait_idle", v, z); check_state("memwait_idle_state", 1'b0);

        // ---- load-use coincident with memory wait ----
        v = '0; v.mem_req = 1; v.m2r_e = 1; v.rw_e = 1; v.ad_e = 8; v.rt_d = 8;
        step("lu_mem_1", v, ms);
        step("lu_mem_2", v, ms);
        v.mem_rdy = 1; step("lu_mem_ready", v, ds);
        v = '0; v.m2r_m = 1; v.rw_m = 1; v.ad_m = 8; v.rt_d = 8; e = z; e.fbd = 1; step("lu_mem_resolved", v, e);

        // ---- beq with producer in E, then forward from M ----
        v = '0; v.br_d = 1; v.rw_e = 1; v.ad_e = 5; v.rs_d = 5; step("beq_stall", v, ds);
        v = '0; v.br_d = 1; v.rw_m = 1; v.ad_m = 5; v.rs_d = 5; e = z; e.fad = 1; step("beq_fwdAD", v, e);

        // ---- reset during div busy and memory WAIT ----
        v = '0; v.md_start_e = 1; v.md_div_e = 1; step("rst_div_start", v, z);
        v = '0; v.mem_req = 1; e = ms; e.busy = 1; step("rst_wait_1", v, e);
        step("rst_wait_2", v, e); check_state("rst_pre_state", 1'b1);
        @(negedge clk);
        drive('0);
        #2 reset = 1'b0;
        #1;
        exp_q.push_back(z); name_q.push_back("rst_async_outputs");
        compare_front();
        check_state("rst_async_state", 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        v = '0;
        for (int k = 0; k < 3; k++) step("rst_release_idle", v, z);
        check_state("rst_release_state", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
